// File: rtl/decode_unit_if.sv
// rtl/decode_unit_if.sv - fetch, forwarding, writeback and decode-output bundle of decode_unit
// E_icode_i/E_dstM_i exist only when DECODE_HAZARD_EN is defined.
interface decode_unit_if;
    logic [3:0]  f_icode_i, f_ifun_i, f_rA_i, f_rB_i, f_stat_i;
    logic [63:0] f_valC_i, f_valP_i;
    logic        D_stall_i, D_bubble_i;
    logic [3:0]  e_dstE_i;
    logic [63:0] e_valE_i;
    logic [3:0]  M_dstE_i, M_dstM_i;
    logic [63:0] M_valE_i, m_valM_i;
    logic [3:0]  W_dstE_i, W_dstM_i;
    logic [63:0] W_valE_i, W_valM_i;
`ifdef DECODE_HAZARD_EN
    logic [3:0]  E_icode_i, E_dstM_i;
`endif
    logic [3:0]  D_icode_o, D_ifun_o, D_stat_o;
    logic [63:0] d_valC_o;
    logic [3:0]  d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o;
    logic [63:0] d_valA_o, d_valB_o;
    logic        d_load_use_o;

    modport master (
        output f_icode_i, f_ifun_i, f_rA_i, f_rB_i, f_stat_i, f_valC_i, f_valP_i,
               D_stall_i, D_bubble_i, e_dstE_i, e_valE_i,
               M_dstE_i, M_dstM_i, M_valE_i, m_valM_i,
               W_dstE_i, W_dstM_i, W_valE_i, W_valM_i,
`ifdef DECODE_HAZARD_EN
               E_icode_i, E_dstM_i,
`endif
        input  D_icode_o, D_ifun_o, D_stat_o, d_valC_o,
               d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o,
               d_valA_o, d_valB_o, d_load_use_o
    );

    modport slave (
        input  f_icode_i, f_ifun_i, f_rA_i, f_rB_i, f_stat_i, f_valC_i, f_valP_i,
               D_stall_i, D_bubble_i, e_dstE_i, e_valE_i,
               M_dstE_i, M_dstM_i, M_valE_i, m_valM_i,
               W_dstE_i, W_dstM_i, W_valE_i, W_valM_i,
`ifdef DECODE_HAZARD_EN
               E_icode_i, E_dstM_i,
`endif
        output D_icode_o, D_ifun_o, D_stat_o, d_valC_o,
               d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o,
               d_valA_o, d_valB_o, d_load_use_o
    );
endinterface

// File: rtl/decode_unit.sv
// rtl/decode_unit.sv - Y86-64 decode stage: D register, 15x64 register file, operand forwarding
// Define DECODE_HAZARD_EN to enable the in-block load/use hazard detector.
module decode_unit (
    input logic         clk_i,
    input logic         rst_i,
    decode_unit_if.slave bus
);
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RRSP    = 4'h4;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] SBUB    = 4'h0;

    logic [3:0]  d_icode, d_ifun, d_ra, d_rb, d_stat;
    logic [63:0] d_valc, d_valp;
    logic [63:0] rf [0:14];

    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] rf_a, rf_b, val_a, val_b;
    logic        load_use;

    // Writeback lands regardless of stall/bubble; dstM is assigned last so it wins on a clash.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_icode <= INOP;
            d_ifun  <= 4'h0;
            d_ra    <= RNONE;
            d_rb    <= RNONE;
            d_valc  <= '0;
            d_valp  <= '0;
            d_stat  <= SBUB;
            for (int i = 0; i < 15; i++) rf[i] <= '0;
        end else begin
            if (bus.W_dstE_i != RNONE) rf[bus.W_dstE_i] <= bus.W_valE_i;
            if (bus.W_dstM_i != RNONE) rf[bus.W_dstM_i] <= bus.W_valM_i;
            if (!bus.D_stall_i) begin
                if (bus.D_bubble_i) begin
                    d_icode <= INOP;
                    d_ifun  <= 4'h0;
                    d_ra    <= RNONE;
                    d_rb    <= RNONE;
                    d_valc  <= '0;
                    d_valp  <= '0;
                    d_stat  <= SBUB;
                end else begin
                    d_icode <= bus.f_icode_i;
                    d_ifun  <= bus.f_ifun_i;
                    d_ra    <= bus.f_rA_i;
                    d_rb    <= bus.f_rB_i;
                    d_valc  <= bus.f_valC_i;
                    d_valp  <= bus.f_valP_i;
                    d_stat  <= bus.f_stat_i;
                end
            end
        end
    end

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (d_icode)
            IRRMOVQ: begin src_a = d_ra; dst_e = d_rb; end
            IIRMOVQ: dst_e = d_rb;
            IRMMOVQ: begin src_a = d_ra; src_b = d_rb; end
            IMRMOVQ: begin src_b = d_rb; dst_m = d_ra; end
            IOPQ:    begin src_a = d_ra; src_b = d_rb; dst_e = d_rb; end
            IPUSHQ:  begin src_a = d_ra; src_b = RRSP; dst_e = RRSP; end
            IPOPQ:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; dst_m = d_ra; end
            ICALL:   begin src_b = RRSP; dst_e = RRSP; end
            IRET:    begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; end
            default: ;
        endcase
    end

    always_comb begin
        rf_a = '0;
        rf_b = '0;
        if (src_a != RNONE) rf_a = rf[src_a];
        if (src_b != RNONE) rf_b = rf[src_b];
    end

    // Youngest producer wins; RNONE never matches so unused operands fall through to 0.
    always_comb begin
        val_a = rf_a;
        if (d_icode == ICALL || d_icode == IJXX)            val_a = d_valp;
        else if (src_a != RNONE && src_a == bus.e_dstE_i)   val_a = bus.e_valE_i;
        else if (src_a != RNONE && src_a == bus.M_dstM_i)   val_a = bus.m_valM_i;
        else if (src_a != RNONE && src_a == bus.M_dstE_i)   val_a = bus.M_valE_i;
        else if (src_a != RNONE && src_a == bus.W_dstM_i)   val_a = bus.W_valM_i;
        else if (src_a != RNONE && src_a == bus.W_dstE_i)   val_a = bus.W_valE_i;
    end

    always_comb begin
        val_b = rf_b;
        if (src_b != RNONE && src_b == bus.e_dstE_i)        val_b = bus.e_valE_i;
        else if (src_b != RNONE && src_b == bus.M_dstM_i)   val_b = bus.m_valM_i;
        else if (src_b != RNONE && src_b == bus.M_dstE_i)   val_b = bus.M_valE_i;
        else if (src_b != RNONE && src_b == bus.W_dstM_i)   val_b = bus.W_valM_i;
        else if (src_b != RNONE && src_b == bus.W_dstE_i)   val_b = bus.W_valE_i;
    end

`ifdef DECODE_HAZARD_EN
    assign load_use = (bus.E_icode_i == IMRMOVQ || bus.E_icode_i == IPOPQ) &&
                      (bus.E_dstM_i != RNONE) &&
                      (bus.E_dstM_i == src_a || bus.E_dstM_i == src_b);
`else
    assign load_use = 1'b0;
`endif

    assign bus.D_icode_o    = d_icode;
    assign bus.D_ifun_o     = d_ifun;
    assign bus.D_stat_o     = d_stat;
    assign bus.d_valC_o     = d_valc;
    assign bus.d_srcA_o     = src_a;
    assign bus.d_srcB_o     = src_b;
    assign bus.d_dstE_o     = dst_e;
    assign bus.d_dstM_o     = dst_m;
    assign bus.d_valA_o     = val_a;
    assign bus.d_valB_o     = val_b;
    assign bus.d_load_use_o = load_use;
endmodule

// File: tb/tb_decode_unit.sv
// tb/tb_decode_unit.sv - directed and randomized checks of decode_unit against a reference model
// Build with DECODE_HAZARD_EN defined to exercise the load/use detector.
module tb_decode_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_unit_if bus();
    decode_unit dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [63:0] m_rf [15];
    logic [3:0]  m_icode, m_ifun, m_ra, m_rb, m_stat;
    logic [63:0] m_valc, m_valp;

    function automatic logic [3:0] exp_src_a(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_src_b(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_dst_e(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_dst_m(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return 4'hF;
    endfunction

    // First matching producer in age order, else register file value (0 for RNONE)
    function automatic logic [63:0] exp_operand(input logic [3:0] src);
        logic [3:0]  dsts [5];
        logic [63:0] vals [5];
        if (src == 4'hF) return 64'h0;
        dsts = '{bus.e_dstE_i, bus.M_dstM_i, bus.M_dstE_i, bus.W_dstM_i, bus.W_dstE_i};
        vals = '{bus.e_valE_i, bus.m_valM_i, bus.M_valE_i, bus.W_valM_i, bus.W_valE_i};
        for (int k = 0; k < 5; k++)
            if (dsts[k] == src) return vals[k];
        return m_rf[src];
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int k = 0; k < 15; k++) m_rf[k] = 64'h0;
            {m_icode, m_ifun, m_ra, m_rb, m_stat} = {4'h1, 4'h0, 4'hF, 4'hF, 4'h0};
            m_valc = 64'h0;
            m_valp = 64'h0;
        end else begin
            if (bus.W_dstE_i != 4'hF) m_rf[bus.W_dstE_i] = bus.W_valE_i;
            if (bus.W_dstM_i != 4'hF) m_rf[bus.W_dstM_i] = bus.W_valM_i;
            if (bus.D_stall_i) begin
            end else if (bus.D_bubble_i) begin
                {m_icode, m_ifun, m_ra, m_rb, m_stat} = {4'h1, 4'h0, 4'hF, 4'hF, 4'h0};
                m_valc = 64'h0;
                m_valp = 64'h0;
            end else begin
                {m_icode, m_ifun, m_ra, m_rb, m_stat} =
                    {bus.f_icode_i, bus.f_ifun_i, bus.f_rA_i, bus.f_rB_i, bus.f_stat_i};
                m_valc = bus.f_valC_i;
                m_valp = bus.f_valP_i;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0]  sa, sb;
        logic [63:0] va;
        logic        lu;
        sa = exp_src_a(m_icode, m_ra);
        sb = exp_src_b(m_icode, m_rb);
        va = (m_icode inside {4'h7, 4'h8}) ? m_valp : exp_operand(sa);
        lu = 1'b0;
`ifdef DECODE_HAZARD_EN
        lu = (bus.E_icode_i inside {4'h5, 4'hB}) && bus.E_dstM_i != 4'hF &&
             (bus.E_dstM_i == sa || bus.E_dstM_i == sb);
`endif
        check({tag, ".D_icode"}, 64'(bus.D_icode_o), 64'(m_icode));
        check({tag, ".D_ifun"},  64'(bus.D_ifun_o),  64'(m_ifun));
        check({tag, ".D_stat"},  64'(bus.D_stat_o),  64'(m_stat));
        check({tag, ".valC"},    bus.d_valC_o,       m_valc);
        check({tag, ".srcA"},    64'(bus.d_srcA_o),  64'(sa));
        check({tag, ".srcB"},    64'(bus.d_srcB_o),  64'(sb));
        check({tag, ".dstE"},    64'(bus.d_dstE_o),  64'(exp_dst_e(m_icode, m_rb)));
        check({tag, ".dstM"},    64'(bus.d_dstM_o),  64'(exp_dst_m(m_icode, m_ra)));
        check({tag, ".valA"},    bus.d_valA_o,       va);
        check({tag, ".valB"},    bus.d_valB_o,       exp_operand(sb));
        check({tag, ".load_use"}, 64'(bus.d_load_use_o), 64'(lu));
    endtask

    task automatic drive_idle();
        bus.f_icode_i = 4'h1; bus.f_ifun_i = 4'h0; bus.f_rA_i = 4'hF; bus.f_rB_i = 4'hF;
        bus.f_stat_i = 4'h1; bus.f_valC_i = 64'h0; bus.f_valP_i = 64'h0;
        bus.D_stall_i = 1'b0; bus.D_bubble_i = 1'b0;
        bus.e_dstE_i = 4'hF; bus.e_valE_i = 64'h0;
        bus.M_dstE_i = 4'hF; bus.M_dstM_i = 4'hF; bus.M_valE_i = 64'h0; bus.m_valM_i = 64'h0;
        bus.W_dstE_i = 4'hF; bus.W_dstM_i = 4'hF; bus.W_valE_i = 64'h0; bus.W_valM_i = 64'h0;
`ifdef DECODE_HAZARD_EN
        bus.E_icode_i = 4'h1; bus.E_dstM_i = 4'hF;
`endif
    endtask

    task automatic set_fetch(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                             input logic [63:0] valc, input logic [63:0] valp);
        bus.f_icode_i = ic; bus.f_ifun_i = 4'h0; bus.f_rA_i = ra; bus.f_rB_i = rb;
        bus.f_stat_i = 4'h1; bus.f_valC_i = valc; bus.f_valP_i = valp;
    endtask

    function automatic logic [3:0] rand_reg();
        return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
    endfunction

    initial begin
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("reset.D_icode", 64'(bus.D_icode_o), 64'h1);
        check("reset.valA", bus.d_valA_o, 64'h0);
        check_outputs("reset");

        // irmovq $5,%rbx
        set_fetch(4'h3, 4'hF, 4'h3, 64'd5, 64'd10);
        tick();
        check("irmovq.D_icode", 64'(bus.D_icode_o), 64'h3);
        check("irmovq.dstE", 64'(bus.d_dstE_o), 64'h3);
        check("irmovq.valC", bus.d_valC_o, 64'd5);
        check_outputs("irmovq");

        // RF write then addq %rbx,%rax reads it; then W forward of same register
        bus.W_dstE_i = 4'h3; bus.W_valE_i = 64'h1234;
        set_fetch(4'h6, 4'h3, 4'h0, 64'h0, 64'd12);
        tick();
        bus.W_dstE_i = 4'hF;
        #1;
        check("addq_rf.valA", bus.d_valA_o, 64'h1234);
        bus.W_dstE_i = 4'h3; bus.W_valE_i = 64'h1234;
        #1;
        check("addq_wfwd.valA", bus.d_valA_o, 64'h1234);
        bus.W_valE_i = 64'h9999;
        #1;
        check("addq_wfwd_new.valA", bus.d_valA_o, 64'h9999);
        check_outputs("addq");
        drive_idle();

        // forwarding priority e > M > W
        set_fetch(4'h2, 4'h2, 4'h5, 64'h0, 64'd14);
        tick();
        bus.e_dstE_i = 4'h2; bus.e_valE_i = 64'hAA;
        bus.M_dstE_i = 4'h2; bus.M_valE_i = 64'hBB;
        bus.W_dstE_i = 4'h2; bus.W_valE_i = 64'hCC;
        #1;
        check("fwd_e.valA", bus.d_valA_o, 64'hAA);
        bus.e_dstE_i = 4'hF;
        #1;
        check("fwd_m.valA", bus.d_valA_o, 64'hBB);
        check_outputs("fwd");
        drive_idle();

        // W_valM wins over W_valE on same register; call takes valP for valA
        bus.W_dstE_i = 4'h4; bus.W_valE_i = 64'h10;
        bus.W_dstM_i = 4'h4; bus.W_valM_i = 64'h20;
        set_fetch(4'h8, 4'hF, 4'hF, 64'h100, 64'h77);
        tick();
        drive_idle();
        #1;
        check("popq_rsp.valB", bus.d_valB_o, 64'h20);
        check("call.valA", bus.d_valA_o, 64'h77);
        check_outputs("call");

        // stall holds, bubble inserts nop, stall+bubble holds
        set_fetch(4'h6, 4'h1, 4'h2, 64'h0, 64'h0);
        bus.D_stall_i = 1'b1;
        tick();
        check("stall.D_icode", 64'(bus.D_icode_o), 64'h8);
        bus.D_stall_i = 1'b0; bus.D_bubble_i = 1'b1;
        tick();
        check("bubble.D_icode", 64'(bus.D_icode_o), 64'h1);
        check("bubble.D_stat", 64'(bus.D_stat_o), 64'h0);
        bus.D_bubble_i = 1'b0;
        tick();
        bus.D_stall_i = 1'b1; bus.D_bubble_i = 1'b1;
        set_fetch(4'h3, 4'hF, 4'h1, 64'h5, 64'h0);
        tick();
        check("stall_bubble.D_icode", 64'(bus.D_icode_o), 64'h6);
        check_outputs("stall_bubble");
        drive_idle();

`ifdef DECODE_HAZARD_EN
        set_fetch(4'h6, 4'h3, 4'h0, 64'h0, 64'h0);
        tick();
        bus.E_icode_i = 4'h5; bus.E_dstM_i = 4'h3;
        #1;
        check("hazard.load_use", 64'(bus.d_load_use_o), 64'h1);
        bus.E_dstM_i = 4'hF;
        #1;
        check("no_hazard.load_use", 64'(bus.d_load_use_o), 64'h0);
        drive_idle();
`endif

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_fetch(4'($urandom_range(0, 13)), rand_reg(), rand_reg(),
                      {$urandom, $urandom}, {$urandom, $urandom});
            bus.f_ifun_i = 4'($urandom_range(0, 15));
            bus.f_stat_i = 4'($urandom_range(0, 4));
            bus.D_stall_i = ($urandom_range(0, 7) == 0);
            bus.D_bubble_i = ($urandom_range(0, 7) == 0);
            bus.e_dstE_i = rand_reg(); bus.e_valE_i = {$urandom, $urandom};
            bus.M_dstE_i = rand_reg(); bus.M_valE_i = {$urandom, $urandom};
            bus.M_dstM_i = rand_reg(); bus.m_valM_i = {$urandom, $urandom};
            bus.W_dstE_i = rand_reg(); bus.W_valE_i = {$urandom, $urandom};
            bus.W_dstM_i = rand_reg(); bus.W_valM_i = {$urandom, $urandom};
`ifdef DECODE_HAZARD_EN
            bus.E_icode_i = ($urandom_range(0, 1) == 0) ? 4'h5 : 4'($urandom_range(0, 11));
            bus.E_dstM_i = rand_reg();
`endif
            #2;
            check_outputs("rand");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/decode_unit.md
# decode_unit

Decode stage of the five-stage Y86-64 pipeline, directly downstream of fetch. Holds the D pipeline register (loaded from fetch outputs, with stall/bubble control), the 15×64-bit architectural register file (written from the W stage), source/destination selection, and the valA/valB forwarding network feeding execute. Removing a separate D-register module, it is the single owner of architectural register state.

## Interface
Parameters:
- none (widths from `define.v`: D_WORD = 64 bits, NIBBLE = 4 bits)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- f_icode_i, f_ifun_i, f_rA_i, f_rB_i, f_stat_i  in  4 each  fetch outputs
- f_valC_i, f_valP_i  in  64  fetch constant / next PC
- D_stall_i, D_bubble_i  in  1  pipeline control
- e_dstE_i  in  4, e_valE_i  in  64  execute-stage forward
- M_dstE_i, M_dstM_i  in  4; M_valE_i, m_valM_i  in  64  memory-stage forward
- W_dstE_i, W_dstM_i  in  4; W_valE_i, W_valM_i  in  64  writeback port and forward
- E_icode_i, E_dstM_i  in  4  (present only with DECODE_HAZARD_EN)
- D_icode_o, D_ifun_o, D_stat_o  out  4  registered D fields
- d_valC_o  out  64  registered valC
- d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o  out  4
- d_valA_o, d_valB_o  out  64  forwarded operands
- d_load_use_o  out  1  load/use hazard request

## Operation
- D register priority per edge: rst_i > D_stall_i (hold) > D_bubble_i (load bubble) > load f_*.
- Bubble/reset contents: icode INOP(1), ifun 0, rA=rB=RNONE(F), valC=valP=0, stat SBUB(0).
- srcA: rA for RRMOVQ, RMMOVQ, OPQ, PUSHQ; RRSP(4) for POPQ, RET; else F.
- srcB: rB for OPQ, RMMOVQ, MRMOVQ; RRSP for PUSHQ, POPQ, CALL, RET; else F.
- dstE: rB for RRMOVQ, IRMOVQ, OPQ; RRSP for PUSHQ, POPQ, CALL, RET; else F.
- dstM: rA for MRMOVQ, POPQ; else F.
- d_valA priority: D_icode CALL or JXX → D_valP; srcA==e_dstE → e_valE; ==M_dstM → m_valM; ==M_dstE → M_valE; ==W_dstM → W_valM; ==W_dstE → W_valE; else RF[srcA].
- d_valB same chain without the valP term.
- Forward match requires src ≠ F; RF read of F returns 0.
- Register file: on edge, write W_valE to W_dstE and W_valM to W_dstM when ≠ F; same register on both → W_valM wins (popq %rsp). Reset clears all 15 registers to 0.
- Writes are not blocked by D_stall_i/D_bubble_i.

## Timing
- D register: one-cycle latency fetch → D_*.
- Decode outputs combinational from D register, RF and forward inputs; same-cycle W write visible via W forward path, RF updated next cycle.
- After reset edge: D_icode_o=1, D_ifun_o=0, D_stat_o=0, d_valC_o=0, all src/dst=F, d_valA_o=d_valB_o=0, d_load_use_o=0.
- Reset mid-stream discards D contents and all RF state in the same edge; W writes in that cycle are dropped.
- Simultaneous stall+bubble: stall wins, D holds.

## Configuration
- DECODE_HAZARD_EN defined: E_icode_i/E_dstM_i ports exist; d_load_use_o = (E_icode ∈ {MRMOVQ, POPQ}) && E_dstM ≠ F && E_dstM ∈ {d_srcA, d_srcB}; combinational.
- Undefined: those ports absent; d_load_use_o tied 0 (external pipeline control owns hazard detection).

## Test plan
- Reset 1 cycle, then irmovq $5,%rbx through f_* → next cycle D_icode_o=3, d_dstE_o=3, d_valC_o=5, srcA=srcB=F.
- W_dstE=3, W_valE=0x1234 one cycle, then decode addq %rbx,%rax (6/0, rA=3, rB=0) → d_valA_o=0x1234 from RF; same cycle W forward also gives 0x1234.
- rA=2 with e_dstE=2/e_valE=0xAA, M_dstE=2/M_valE=0xBB, W_dstE=2/W_valE=0xCC → d_valA_o=0xAA; drop e match → 0xBB.
- W_dstE=4/W_valE=0x10 and W_dstM=4/W_valM=0x20 same edge → RF[4]=0x20; call in D → d_valA_o=D_valP.
- D_stall_i=1 while f_* changes → D_* held; D_bubble_i=1 → D_icode_o=1, D_stat_o=0; both → held.
- DECODE_HAZARD_EN: E_icode=5, E_dstM=3, D decodes opq rA=3 → d_load_use_o=1; E_dstM=F → 0.
